// File: rtl/core_bus_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the single memory-side port.
// slave = arbiter side, master = the core plus memory around it.
interface core_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_addr_ok;
  logic              iresp_data_ok;
  logic [31:0]       iresp_data;

  logic              dreq_valid;
  logic [ADDR_W-1:0] dreq_addr;
  logic [2:0]        dreq_size;
  logic [STRB_W-1:0] dreq_strobe;
  logic [DATA_W-1:0] dreq_data;
  logic              dresp_addr_ok;
  logic              dresp_data_ok;
  logic [DATA_W-1:0] dresp_data;

  logic              oreq_valid;
  logic [ADDR_W-1:0] oreq_addr;
  logic [2:0]        oreq_size;
  logic [STRB_W-1:0] oreq_strobe;
  logic [DATA_W-1:0] oreq_data;
  logic              oresp_data_ok;
  logic [DATA_W-1:0] oresp_data;

  logic              grant_d;

  modport slave (
    input  ireq_valid, ireq_addr,
    output iresp_addr_ok, iresp_data_ok, iresp_data,
    input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output oreq_valid, oreq_addr, oreq_size, oreq_strobe, oreq_data,
    input  oresp_data_ok, oresp_data,
    output grant_d
  );

  modport master (
    output ireq_valid, ireq_addr,
    input  iresp_addr_ok, iresp_data_ok, iresp_data,
    output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  oreq_valid, oreq_addr, oreq_size, oreq_strobe, oreq_data,
    output oresp_data_ok, oresp_data,
    input  grant_d
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Serialises fetch and data requests onto one memory port, one transaction outstanding.
// Optional ARB_ROUND_ROBIN_EN alternates ties between requesters; default is data-bus priority.
module core_bus_arbiter #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  core_bus_arbiter_if.slave   io_bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [2:0]  MSIZE4 = 3'd2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [STRB_W-1:0] r_strobe;
  logic [DATA_W-1:0] r_data;

  logic w_idle;
  logic w_busy_i;
  logic w_busy_d;
  logic w_busy;
  logic w_pick_d;
  logic w_pick_i;
  logic w_fetch_hit;
  logic w_data_hit;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_busy_i = (r_state == ST_BUSY_I);
  assign w_busy_d = (r_state == ST_BUSY_D);
  assign w_busy   = w_busy_i | w_busy_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data bus received the most recent grant
  logic r_last_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (w_idle && (w_pick_d || w_pick_i)) begin
      r_last_d <= w_pick_d;
    end
  end

  assign w_pick_d = io_bus.dreq_valid && !(io_bus.ireq_valid && r_last_d);
`else
  assign w_pick_d = io_bus.dreq_valid;
`endif
  assign w_pick_i = io_bus.ireq_valid && !w_pick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_d) begin
          w_state_nxt = ST_BUSY_D;
        end else if (w_pick_i) begin
          w_state_nxt = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (io_bus.oresp_data_ok) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant register: captured only in IDLE, frozen for the whole transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_size   <= '0;
      r_strobe <= '0;
      r_data   <= '0;
    end else if (w_idle) begin
      if (w_pick_d) begin
        r_addr   <= io_bus.dreq_addr;
        r_size   <= io_bus.dreq_size;
        r_strobe <= io_bus.dreq_strobe;
        r_data   <= io_bus.dreq_data;
      end else if (w_pick_i) begin
        r_addr   <= io_bus.ireq_addr;
        r_size   <= MSIZE4;
        r_strobe <= '0;
        r_data   <= '0;
      end
    end
  end

  assign io_bus.oreq_valid  = w_busy;
  assign io_bus.oreq_addr   = w_busy ? r_addr   : '0;
  assign io_bus.oreq_size   = w_busy ? r_size   : '0;
  assign io_bus.oreq_strobe = w_busy ? r_strobe : '0;
  assign io_bus.oreq_data   = w_busy ? r_data   : '0;
  assign io_bus.grant_d     = w_busy_d;

  // A fetch whose address moved on while in flight is completed downstream but not reported
  assign w_fetch_hit = w_busy_i && io_bus.oresp_data_ok && (io_bus.ireq_addr == r_addr);
  assign w_data_hit  = w_busy_d && io_bus.oresp_data_ok;

  assign io_bus.iresp_addr_ok = w_idle && w_pick_i;
  assign io_bus.iresp_data_ok = w_fetch_hit;
  assign io_bus.iresp_data    = !w_fetch_hit ? 32'h0 :
                                (r_addr[2] ? io_bus.oresp_data[63:32] : io_bus.oresp_data[31:0]);

  assign io_bus.dresp_addr_ok = w_idle && w_pick_d;
  assign io_bus.dresp_data_ok = w_data_hit;
  assign io_bus.dresp_data    = w_data_hit ? io_bus.oresp_data : '0;
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Scoreboard bench for core_bus_arbiter: random fetch/data traffic against a random-latency memory.
module tb_core_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;

  core_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  core_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } req_t;

  typedef struct {
    bit          is_d;
    logic [63:0] data;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   m_last_d = 1'b0;
  int   mem_min = 0;
  bit   mem_en = 1'b1;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endfunction

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    return {a[31:0] ^ 32'h9111_2226, a[31:0] ^ 32'hB333_4440};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [63:0] a);
    logic [63:0] w;
    w = mem_fn(a);
    return a[2] ? w[63:32] : w[31:0];
  endfunction

  function automatic void push_req_i(input logic [63:0] a);
    exp_req_q.push_back('{1'b0, a, 3'd2, 8'h00, 64'h0});
  endfunction

  function automatic void push_rsp_i(input logic [63:0] a);
    exp_rsp_q.push_back('{1'b0, {32'h0, fetch_word(a)}});
  endfunction

  function automatic void push_d(input logic [63:0] a, input logic [2:0] sz,
                                 input logic [7:0] stb, input logic [63:0] dat);
    exp_req_q.push_back('{1'b1, a, sz, stb, dat});
    exp_rsp_q.push_back('{1'b1, mem_fn(a)});
  endfunction

  // Memory: answers each request after a random 0..3 (+mem_min) cycle wait
  int mem_lat = 0;
  int mem_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      if (bus.oreq_valid) begin
        if (mem_cnt == mem_lat) begin
          bus.oresp_data_ok = 1'b1;
          bus.oresp_data    = mem_fn(bus.oreq_addr);
        end else begin
          bus.oresp_data_ok = 1'b0;
          bus.oresp_data    = 64'h0;
        end
        mem_cnt++;
      end else begin
        bus.oresp_data_ok = 1'b0;
        bus.oresp_data    = 64'h0;
        mem_cnt = 0;
        mem_lat = $urandom_range(mem_min + 3, mem_min);
      end
    end
  end

  // Monitor: compares downstream requests and upstream responses against the queues
  bit prev_valid = 1'b0;
  bit prev_iaok = 1'b0;
  bit prev_daok = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_iaok  = 1'b0;
      prev_daok  = 1'b0;
    end else begin
      check("addr_ok_exclusive", 64'(bus.iresp_addr_ok & bus.dresp_addr_ok), 64'h0);
      if (bus.oreq_valid) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_oreq", 64'(bus.oreq_valid), 64'h0);
        end else begin
          req_t r;
          r = exp_req_q[0];
          if (!prev_valid)
            check("grant_addr_ok", 64'(r.is_d ? prev_daok : prev_iaok), 64'h1);
          check("oreq_addr", bus.oreq_addr, r.addr);
          check("oreq_size", 64'(bus.oreq_size), 64'(r.size));
          check("oreq_strobe", 64'(bus.oreq_strobe), 64'(r.strobe));
          check("oreq_data", bus.oreq_data, r.data);
          check("grant_d", 64'(bus.grant_d), 64'(r.is_d));
          if (bus.oresp_data_ok) void'(exp_req_q.pop_front());
        end
      end
      if (bus.iresp_data_ok || bus.dresp_data_ok) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_resp", 64'({bus.iresp_data_ok, bus.dresp_data_ok}), 64'h0);
        end else begin
          rsp_t s;
          s = exp_rsp_q.pop_front();
          check("resp_owner_d", 64'(bus.dresp_data_ok), 64'(s.is_d));
          check("resp_owner_i", 64'(bus.iresp_data_ok), 64'(!s.is_d));
          if (s.is_d) check("dresp_data", bus.dresp_data, s.data);
          else        check("iresp_data", 64'(bus.iresp_data), s.data);
        end
      end
      prev_valid = bus.oreq_valid;
      prev_iaok  = bus.iresp_addr_ok;
      prev_daok  = bus.dresp_addr_ok;
    end
  end

  task automatic issue(input bit use_i, input logic [63:0] ia,
                       input bit use_d, input logic [63:0] da, input logic [2:0] dsz,
                       input logic [7:0] dstb, input logic [63:0] ddat);
    bit d_first;
    bit i_done;
    bit d_done;
`ifdef ARB_ROUND_ROBIN_EN
    d_first = !m_last_d;
`else
    d_first = 1'b1;
`endif
    if (use_i && use_d) begin
      if (d_first) begin
        push_d(da, dsz, dstb, ddat); push_req_i(ia); push_rsp_i(ia);
        m_last_d = 1'b0;
      end else begin
        push_req_i(ia); push_rsp_i(ia); push_d(da, dsz, dstb, ddat);
        m_last_d = 1'b1;
      end
    end else if (use_d) begin
      push_d(da, dsz, dstb, ddat);
      m_last_d = 1'b1;
    end else if (use_i) begin
      push_req_i(ia); push_rsp_i(ia);
      m_last_d = 1'b0;
    end
    bus.ireq_valid  = use_i;
    bus.ireq_addr   = ia;
    bus.dreq_valid  = use_d;
    bus.dreq_addr   = da;
    bus.dreq_size   = dsz;
    bus.dreq_strobe = dstb;
    bus.dreq_data   = ddat;
    i_done = !use_i;
    d_done = !use_d;
    for (int c = 0; c < 60 && !(i_done && d_done); c++) begin
      @(negedge clk);
      if (bus.dresp_data_ok) d_done = 1'b1;
      if (bus.iresp_data_ok) i_done = 1'b1;
      @(posedge clk); #1;
      if (d_done) bus.dreq_valid = 1'b0;
      if (i_done) bus.ireq_valid = 1'b0;
    end
    if (!(i_done && d_done)) begin
      check("txn_timeout", 64'h0, 64'h1);
      exp_req_q.delete();
      exp_rsp_q.delete();
      bus.ireq_valid = 1'b0;
      bus.dreq_valid = 1'b0;
    end
  endtask

  task automatic flush_fetch(input logic [63:0] ia0, input logic [63:0] ia1);
    bit seen;
    bit done;
    mem_min = 2;
    @(posedge clk); #1;
    push_req_i(ia0);
    push_req_i(ia1); push_rsp_i(ia1);
    m_last_d = 1'b0;
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = ia0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.oreq_valid) seen = 1'b1;
    end
    check("flush_oreq_seen", 64'(seen), 64'h1);
    @(posedge clk); #1;
    bus.ireq_addr = ia1;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (bus.iresp_data_ok) done = 1'b1;
    end
    check("flush_refetch_done", 64'(done), 64'h1);
    @(posedge clk); #1;
    bus.ireq_valid = 1'b0;
    mem_min = 0;
    if (!done) begin
      exp_req_q.delete();
      exp_rsp_q.delete();
    end
  endtask

  task automatic reset_mid_store();
    bit seen;
    mem_min = 3;
    @(posedge clk); #1;
    exp_req_q.push_back('{1'b1, 64'h8000_2000, 3'd3, 8'hFF, 64'hDEAD_BEEF_0000_0001});
    bus.dreq_valid  = 1'b1;
    bus.dreq_addr   = 64'h8000_2000;
    bus.dreq_size   = 3'd3;
    bus.dreq_strobe = 8'hFF;
    bus.dreq_data   = 64'hDEAD_BEEF_0000_0001;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.oreq_valid) seen = 1'b1;
    end
    check("rst_oreq_seen", 64'(seen), 64'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_req_q.delete();
    exp_rsp_q.delete();
    bus.dreq_valid = 1'b0;
    m_last_d = 1'b0;
    mem_min = 0;
    #1;
    check("rst_mid_oreq_valid", 64'(bus.oreq_valid), 64'h0);
    check("rst_mid_grant_d", 64'(bus.grant_d), 64'h0);
    check("rst_mid_oreq_addr", bus.oreq_addr, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1'b0, 64'h0, 1'b1, 64'h8000_3008, 3'd2, 8'h0F, 64'h0123_4567_89AB_CDEF);
  endtask

  task automatic stray_response();
    mem_en = 1'b0;
    @(posedge clk); #1;
    bus.oresp_data_ok = 1'b1;
    bus.oresp_data    = 64'hCAFE_F00D_1234_5678;
    #3;
    check("stray_iresp_data_ok", 64'(bus.iresp_data_ok), 64'h0);
    check("stray_dresp_data_ok", 64'(bus.dresp_data_ok), 64'h0);
    @(posedge clk); #1;
    bus.oresp_data_ok = 1'b0;
    bus.oresp_data    = 64'h0;
    check("stray_oreq_valid", 64'(bus.oreq_valid), 64'h0);
    check("stray_grant_d", 64'(bus.grant_d), 64'h0);
    mem_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ireq_valid    = 1'b0;
    bus.ireq_addr     = 64'h0;
    bus.dreq_valid    = 1'b0;
    bus.dreq_addr     = 64'h0;
    bus.dreq_size     = 3'd0;
    bus.dreq_strobe   = 8'h0;
    bus.dreq_data     = 64'h0;
    bus.oresp_data_ok = 1'b0;
    bus.oresp_data    = 64'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oreq_valid", 64'(bus.oreq_valid), 64'h0);
    check("rst_oreq_addr", bus.oreq_addr, 64'h0);
    check("rst_grant_d", 64'(bus.grant_d), 64'h0);
    check("rst_iresp_data_ok", 64'(bus.iresp_data_ok), 64'h0);
    check("rst_dresp_data_ok", 64'(bus.dresp_data_ok), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    issue(1'b1, 64'h8000_0004, 1'b0, 64'h0, 3'd0, 8'h0, 64'h0);
    issue(1'b1, 64'h8000_0040, 1'b1, 64'h8000_1000, 3'd3, 8'hFF, 64'hA5A5_5A5A_0F0F_F0F0);
    flush_fetch(64'h8000_0010, 64'h8000_0100);
    stray_response();
    reset_mid_store();
    for (int k = 0; k < 4; k++)
      issue(1'b1, 64'h8000_0200 + 64'(k * 4), 1'b1, 64'h8000_4000 + 64'(k * 8),
            3'd3, 8'hFF, 64'(k));

    for (int n = 0; n < 60; n++) begin
      int          mode;
      logic [63:0] ia;
      logic [63:0] da;
      mode = $urandom_range(2, 0);
      ia = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
      da = {32'h0, 32'h9000_0000 | ($urandom & 32'h0000_FFF8)};
      issue(mode != 1, ia, mode != 0, da, 3'($urandom_range(3, 0)),
            8'($urandom), {$urandom, $urandom});
    end

    repeat (5) @(posedge clk);
    #1;
    check("exp_req_q_empty", 64'(exp_req_q.size()), 64'h0);
    check("exp_rsp_q_empty", 64'(exp_rsp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
